// File: rtl/network_mul_arb_pkg.sv
// Shared definitions for the multiplier arbiter: datapath widths, default
// parameters and the tag type carried alongside each multiplier operation.
package network_mul_arb_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned PROD_W      = 30;
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned MUL_LAT_DEF = 2;
    localparam int unsigned ID_W_DEF    = 2;
    // Tag ID field is sized for the largest legal requester count (8).
    localparam int unsigned MAX_ID_W    = 3;

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/network_rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   en    : allow a grant this cycle
//   ptr   : highest-priority index; search wraps upward from here
//   grant : one-hot grant (zero when nothing granted)
//   idx   : encoded index of the granted requester
//   any   : a grant was issued
module network_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            k = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (en && !any && req[k]) begin
                grant[k] = 1'b1;
                idx      = k;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/network_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined signed multiplier among
// NUM_REQ requesters. A tag pipe matched to the multiplier latency carries
// the requester ID so each product returns with its origin.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req_valid/req_ready per-requester operand handshake (ready one-hot or zero)
//   req_a/req_b         packed signed operands, requester i at [16*i+:16]
//   mul_ce/din0/din1    drive to the external multiplier
//   mul_dout            product from the external multiplier
//   rsp_valid/ready     response handshake
//   rsp_id/rsp_p        originating requester and 30-bit product
//   stat_grants         (MUL_ARB_STATS_EN) per-requester handshake counters
//   stat_stall_cycles   (MUL_ARB_STATS_EN) cycles with the pipe frozen
//
// Build option: define MUL_ARB_STATS_EN to add the statistics outputs.
module network_mul_arbiter
    import network_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      mul_ce,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [DATA_W-1:0]         mul_din1,
    input  logic [PROD_W-1:0]         mul_dout,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [PROD_W-1:0]         rsp_p
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants,
    output logic [15:0]               stat_stall_cycles
`endif
);

    logic               advance;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    tag_t               tag_q [MUL_LAT];
    tag_t               tag_in;
    logic               unused_tag_id;

    // Multiplier and tags move together; a held response freezes both.
    assign advance = !rsp_valid || rsp_ready;
    assign mul_ce  = advance;

    // Gating with reset keeps req_ready low for the whole reset window.
    network_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .en    (advance & reset),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req_ready = grant;

    // Bubbles feed zeros so the multiplier never sees stale operands.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        if (grant_any) begin
            mul_din0 = req_a[DATA_W*grant_idx +: DATA_W];
            mul_din1 = req_b[DATA_W*grant_idx +: DATA_W];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        tag_in     = '0;
        tag_in.vld = grant_any;
        tag_in.id  = MAX_ID_W'(grant_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (advance) begin
                tag_q[0] <= tag_in;
                for (int unsigned i = 1; i < MUL_LAT; i++) begin
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    assign rsp_valid = tag_q[MUL_LAT-1].vld;
    assign rsp_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
    assign rsp_p     = mul_dout;

    // Upper tag ID bits are only populated when NUM_REQ needs them.
    assign unused_tag_id = ^tag_q[MUL_LAT-1].id;

`ifdef MUL_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q;
    logic [15:0]              stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
            if (!advance) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign stat_grants       = grant_cnt_q;
    assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule
